lfsr_server: RTL and testbench

Shared random-number server: one 32-bit Fibonacci LFSR time-shared between `NREQ` requesters through a round-robin arbiter. Each grant delivers a unique LFSR word and advances the register by exactly one step. The block also sequences reseeding and a warm-up phase that discards the first `WARMUP` states after reset or reseed. It sits between the pseudo-random source and its consumers, such as test-pattern generators and scramblers.

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/lfsr_step.sv | 38 +++
 rtl/lfsr_server.sv | 128 ++++++++++++
 tb/tb_lfsr_server.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random-number server.
// Purely declarative: no latency, no flow control.
package lfsr_pkg;

    localparam int LFSR_W = 32;

    // Taps at bits 31, 21, 1 and 0.
    localparam logic [LFSR_W-1:0] TAP_MASK = 32'h8020_0003;

    typedef enum logic {
        WARMUP,
        READY
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] q);
        return {^(q & TAP_MASK), q[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// 32-bit Fibonacci LFSR register with synchronous load and step enable.
// Load and step take effect at the next edge; load wins over en; no backpressure.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_value,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = load_value;
        end else if (en) begin
            lfsr_d = lfsr_advance(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/lfsr_server.sv
// Round-robin server handing out one unique LFSR word per grant, with reseed and warm-up sequencing.
// One-cycle grant latency, one word per cycle; requests wait (held level) while busy or not chosen.
module lfsr_server
    import lfsr_pkg::*;
#(
    parameter int                NREQ   = 4,
    parameter logic [LFSR_W-1:0] SEED   = 32'h0000_0001,
    parameter int                WARMUP = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_value,
    output logic [NREQ-1:0]   gnt,
    output logic [LFSR_W-1:0] rnd_data,
    output logic              busy
);

    localparam int PW    = $clog2(NREQ);
    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP == 0) ? 0 : WARMUP - 1);
    localparam logic [PW-1:0]    PTR_RST   = PW'(NREQ - 1);
    localparam state_t INIT_STATE = (WARMUP == 0) ? lfsr_pkg::READY : lfsr_pkg::WARMUP;

    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_server: SEED must be nonzero");
    end
    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
        $error("lfsr_server: NREQ must be in 2..16");
    end
    if (WARMUP < 0 || WARMUP > 1023) begin : g_bad_warmup
        $error("lfsr_server: WARMUP must be in 0..1023");
    end

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [LFSR_W-1:0] rnd_q, rnd_d;

    logic              lfsr_en;
    logic              lfsr_load;
    logic [LFSR_W-1:0] lfsr_load_value;
    logic [LFSR_W-1:0] lfsr_q;
    logic              found;
    logic [PW-1:0]     win;
    logic [PW-1:0]     idx;

    lfsr_step #(
        .SEED(SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .en         (lfsr_en),
        .load       (lfsr_load),
        .load_value (lfsr_load_value),
        .q          (lfsr_q)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        ptr_d           = ptr_q;
        gnt_d           = '0;
        rnd_d           = rnd_q;
        lfsr_en         = 1'b0;
        lfsr_load       = 1'b0;
        lfsr_load_value = SEED;
        found           = 1'b0;
        win             = '0;
        idx             = '0;

        // A zero seed would lock the register, so it is replaced by SEED.
        if (seed_load) begin
            lfsr_load       = 1'b1;
            lfsr_load_value = (seed_value == '0) ? SEED : seed_value;
            cnt_d           = '0;
            state_d         = INIT_STATE;
        end else begin
            case (state_q)
                lfsr_pkg::WARMUP: begin
                    lfsr_en = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == WARM_LAST) begin
                        state_d = lfsr_pkg::READY;
                    end
                end
                default: begin
                    for (int i = 1; i <= NREQ; i++) begin
                        idx = PW'((int'(ptr_q) + i) % NREQ);
                        if (!found && req[idx]) begin
                            found = 1'b1;
                            win   = idx;
                        end
                    end
                    if (found) begin
                        gnt_d   = NREQ'(1) << win;
                        rnd_d   = lfsr_q;
                        lfsr_en = 1'b1;
                        ptr_d   = win;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT_STATE;
            cnt_q   <= '0;
            ptr_q   <= PTR_RST;
            gnt_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            rnd_q   <= rnd_d;
        end
    end

    assign gnt      = gnt_q;
    assign rnd_data = rnd_q;
    assign busy     = (state_q == lfsr_pkg::WARMUP);

endmodule

// File: tb/tb_lfsr_server.sv
// Bench for lfsr_server: three instances (WARMUP 0, 2, 4) share stimulus and are
// checked every cycle against a behavioural model, plus a vector table and corner sequences.
module tb_lfsr_server;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [3:0]       req;
    logic             seed_load;
    logic [31:0]      seed_value;
    logic [2:0][3:0]  gnt_o;
    logic [2:0][31:0] rnd_o;
    logic [2:0]       busy_o;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        lfsr_server #(
            .NREQ   (4),
            .SEED   (32'h0000_0001),
            .WARMUP (2 * g)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req        (req),
            .seed_load  (seed_load),
            .seed_value (seed_value),
            .gnt        (gnt_o[g]),
            .rnd_data   (rnd_o[g]),
            .busy       (busy_o[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Model: register value, warm-up cycles still to run, last winner, output registers.
    logic [31:0] m_lfsr [3];
    int          m_left [3];
    int          m_last [3];
    logic [3:0]  m_gnt  [3];
    logic [31:0] m_rnd  [3];

    typedef struct {
        logic [3:0]  rq;
        logic        sl;
        logic [31:0] sv;
        logic [3:0]  exp_gnt;
        logic [31:0] exp_rnd;
    } vec_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] q);
        return {q[0] ^ q[1] ^ q[21] ^ q[31], q[31:1]};
    endfunction

    function automatic logic [31:0] lfsr_adv(input logic [31:0] q, input int n);
        logic [31:0] v;
        v = q;
        for (int i = 0; i < n; i++) v = lfsr_next(v);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_lfsr[i] = 32'h0000_0001;
            m_left[i] = 2 * i;
            m_last[i] = 3;
            m_gnt[i]  = 4'b0;
            m_rnd[i]  = 32'h0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int win;
            win      = -1;
            m_gnt[i] = 4'b0;
            if (seed_load) begin
                m_lfsr[i] = (seed_value == 32'h0) ? 32'h0000_0001 : seed_value;
                m_left[i] = 2 * i;
            end else if (m_left[i] > 0) begin
                m_lfsr[i] = lfsr_next(m_lfsr[i]);
                m_left[i] = m_left[i] - 1;
            end else if (req != 4'b0) begin
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (m_last[i] + k) % 4;
                    if (win < 0 && req[c]) win = c;
                end
                m_gnt[i]  = 4'b1 << win;
                m_rnd[i]  = m_lfsr[i];
                m_lfsr[i] = lfsr_next(m_lfsr[i]);
                m_last[i] = win;
            end
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("model gnt[w%0d]", 2 * i), 32'(gnt_o[i]), 32'(m_gnt[i]));
            check($sformatf("model rnd[w%0d]", 2 * i), rnd_o[i], m_rnd[i]);
            check($sformatf("model busy[w%0d]", 2 * i), 32'(busy_o[i]), 32'(m_left[i] > 0));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) model_step();
        #1;
        check_model();
    endtask

    initial begin
        vec_t tbl [15];
        int   n;

        tbl[0]  = '{4'b0001, 1'b0, 32'h0,         4'b0001, 32'h0000_0001};
        tbl[1]  = '{4'b0001, 1'b0, 32'h0,         4'b0001, 32'h8000_0000};
        tbl[2]  = '{4'b0001, 1'b0, 32'h0,         4'b0001, 32'hC000_0000};
        tbl[3]  = '{4'b0001, 1'b0, 32'h0,         4'b0001, 32'hE000_0000};
        tbl[4]  = '{4'b1111, 1'b0, 32'h0,         4'b0010, 32'hF000_0000};
        tbl[5]  = '{4'b1111, 1'b0, 32'h0,         4'b0100, 32'hF800_0000};
        tbl[6]  = '{4'b1111, 1'b0, 32'h0,         4'b1000, 32'hFC00_0000};
        tbl[7]  = '{4'b1111, 1'b0, 32'h0,         4'b0001, 32'hFE00_0000};
        tbl[8]  = '{4'b1111, 1'b0, 32'h0,         4'b0010, 32'hFF00_0000};
        tbl[9]  = '{4'b1111, 1'b1, 32'h0,         4'b0000, 32'hFF00_0000};
        tbl[10] = '{4'b1111, 1'b0, 32'h0,         4'b0100, 32'h0000_0001};
        tbl[11] = '{4'b0000, 1'b0, 32'h0,         4'b0000, 32'h0000_0001};
        tbl[12] = '{4'b1000, 1'b0, 32'h0,         4'b1000, 32'h8000_0000};
        tbl[13] = '{4'b0011, 1'b0, 32'h0,         4'b0001, 32'hC000_0000};
        tbl[14] = '{4'b0010, 1'b0, 32'h0,         4'b0010, 32'hE000_0000};

        rst        = 1'b1;
        req        = 4'b0;
        seed_load  = 1'b0;
        seed_value = 32'h0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset gnt[%0d]", i), 32'(gnt_o[i]), 32'h0);
            check($sformatf("reset rnd[%0d]", i), rnd_o[i], 32'h0);
            check($sformatf("reset busy[%0d]", i), 32'(busy_o[i]), 32'(i != 0));
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Vector table on the WARMUP=0 instance.
        for (int v = 0; v < 15; v++) begin
            req        = tbl[v].rq;
            seed_load  = tbl[v].sl;
            seed_value = tbl[v].sv;
            cycle();
            check($sformatf("tbl%0d gnt", v), 32'(gnt_o[0]), 32'(tbl[v].exp_gnt));
            check($sformatf("tbl%0d rnd", v), rnd_o[0], tbl[v].exp_rnd);
        end

        // Warm-up after reset on the WARMUP=2 instance.
        rst = 1'b1;
        model_reset();
        req       = 4'b0001;
        seed_load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n   = 0;
        while (busy_o[1] && n < 10) begin
            cycle();
            n++;
        end
        check("w2 busy cycles", 32'(n), 32'd2);
        cycle();
        check("w2 first gnt", 32'(gnt_o[1]), 32'h1);
        check("w2 first rnd", rnd_o[1], 32'hC000_0000);

        // Reseed with DEADBEEF on the WARMUP=4 instance.
        req        = 4'b1111;
        seed_load  = 1'b1;
        seed_value = 32'hDEAD_BEEF;
        cycle();
        seed_load = 1'b0;
        n = 0;
        while (busy_o[2] && n < 20) begin
            cycle();
            n++;
        end
        check("w4 reseed busy cycles", 32'(n), 32'd4);
        cycle();
        check("w4 reseed gnt", 32'(gnt_o[2]), 32'h1);
        check("w4 reseed rnd", rnd_o[2], lfsr_adv(32'hDEAD_BEEF, 4));

        // Async reset while grants are streaming.
        req = 4'b1111;
        cycle();
        cycle();
        check("w0 gnt active before reset", 32'(gnt_o[0] != 4'b0), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("async rst gnt[%0d]", i), 32'(gnt_o[i]), 32'h0);
            check($sformatf("async rst rnd[%0d]", i), rnd_o[i], 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        cycle();
        check("post-reset gnt", 32'(gnt_o[0]), 32'h1);
        check("post-reset rnd", rnd_o[0], 32'h0000_0001);

        // Randomised traffic, reseeds and zero seeds against the model.
        for (int t = 0; t < 400; t++) begin
            req        = 4'($urandom_range(0, 15));
            seed_load  = ($urandom_range(0, 15) == 0);
            seed_value = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
